// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard controller for the 5-stage core.
//   Detects load-use hazards between EX and ID, stalls for exactly one cycle,
//   flushes IF_ID on a taken branch, and freezes the whole pipeline while the
//   data memory is busy. Priority: freeze > load-use stall > branch flush.
//   Control outputs are combinational from the state and the current inputs.
//
// Ports:
//   clk_i                   clock, rising edge
//   rst_i                   asynchronous active-low reset
//   ID_RS1addr_i/RS2addr_i  source registers of the instruction in ID
//   ID_Branch_taken_i       branch resolved taken in ID
//   EX_MemRead_i            MemRead of the instruction in EX
//   EX_RDaddr_i             destination register of the instruction in EX
//   dmem_ready_i            data memory ready (0 = access in progress)
//   PC_write_o              PC update enable
//   IFID_write_o            IF_ID load enable
//   IFID_flush_o            replace the IF_ID instruction with a NOP
//   IDEX_bubble_o           zero the control word entering ID_EX
//   freeze_o                hold all pipeline registers
//   stall_cnt_o/flush_cnt_o saturating performance counters
//
// Build option: define HAZARD_PERF_CNT_EN to implement the performance
// counters; otherwise both counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_RS1addr_i,
    input  logic [4:0]       ID_RS2addr_i,
    input  logic             ID_Branch_taken_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_RDaddr_i,
    input  logic             dmem_ready_i,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FREEZE   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   lu_c;

    // Load-use hazard; x0 never carries a dependency.
    assign lu_c = EX_MemRead_i
               && (EX_RDaddr_i != REG_W'(0))
               && ((EX_RDaddr_i == ID_RS1addr_i) || (EX_RDaddr_i == ID_RS2addr_i));

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control outputs. FREEZE with memory ready behaves as RUN.
    always_comb begin
        state_d       = ST_RUN;
        PC_write_o    = 1'b1;
        IFID_write_o  = 1'b1;
        IFID_flush_o  = 1'b0;
        IDEX_bubble_o = 1'b0;
        freeze_o      = 1'b0;

        if (!rst_i) begin
            // Reset presents a safe pipeline: nothing advances, bubble into EX.
            PC_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_bubble_o = 1'b1;
        end else if (!dmem_ready_i) begin
            PC_write_o   = 1'b0;
            IFID_write_o = 1'b0;
            freeze_o     = 1'b1;
            state_d      = ST_FREEZE;
        end else if (lu_c && (state_q != ST_LU_STALL)) begin
            // Branch is ignored here; it re-resolves once the load data arrives.
            PC_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_bubble_o = 1'b1;
            state_d       = ST_LU_STALL;
        end else begin
            IFID_flush_o = ID_Branch_taken_i;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counters; the reset bubble is excluded by the async reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (IDEX_bubble_o && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (IFID_flush_o && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl: directed scenarios
// followed by randomized traffic, all compared against a cycle-level model.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic [4:0]       ID_RS1addr_i = '0;
    logic [4:0]       ID_RS2addr_i = '0;
    logic             ID_Branch_taken_i = 1'b0;
    logic             EX_MemRead_i = 1'b0;
    logic [4:0]       EX_RDaddr_i = '0;
    logic             dmem_ready_i = 1'b1;
    logic             PC_write_o;
    logic             IFID_write_o;
    logic             IFID_flush_o;
    logic             IDEX_bubble_o;
    logic             freeze_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    int checks = 0;
    int errors = 0;

    // Model: whether the previous cycle was a load-use stall, plus event counts.
    bit m_stalled = 1'b0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .ID_RS1addr_i      (ID_RS1addr_i),
        .ID_RS2addr_i      (ID_RS2addr_i),
        .ID_Branch_taken_i (ID_Branch_taken_i),
        .EX_MemRead_i      (EX_MemRead_i),
        .EX_RDaddr_i       (EX_RDaddr_i),
        .dmem_ready_i      (dmem_ready_i),
        .PC_write_o        (PC_write_o),
        .IFID_write_o      (IFID_write_o),
        .IFID_flush_o      (IFID_flush_o),
        .IDEX_bubble_o     (IDEX_bubble_o),
        .freeze_o          (freeze_o),
        .stall_cnt_o       (stall_cnt_o),
        .flush_cnt_o       (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check against the model,
    // then advance the model to what the next rising edge will commit.
    task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic br, input logic mr, input logic [4:0] rd,
                        input logic rdy);
        bit lu;
        bit e_pc, e_ifw, e_fl, e_bub, e_frz;
        @(negedge clk_i);
        rst_i = rst; ID_RS1addr_i = rs1; ID_RS2addr_i = rs2; ID_Branch_taken_i = br;
        EX_MemRead_i = mr; EX_RDaddr_i = rd; dmem_ready_i = rdy;
        #1;
        lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_frz = 0;
        if (!rst) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else if (!rdy) begin
            e_pc = 0; e_ifw = 0; e_frz = 1;
        end else if (lu && !m_stalled) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
        end else begin
            e_fl = br;
        end
        check("pc_write",    32'(PC_write_o),    32'(e_pc));
        check("ifid_write",  32'(IFID_write_o),  32'(e_ifw));
        check("ifid_flush",  32'(IFID_flush_o),  32'(e_fl));
        check("idex_bubble", 32'(IDEX_bubble_o), 32'(e_bub));
        check("freeze",      32'(freeze_o),      32'(e_frz));
        check("stall_cnt",   32'(stall_cnt_o),   PERF ? 32'(m_stall_cnt) : 32'd0);
        check("flush_cnt",   32'(flush_cnt_o),   PERF ? 32'(m_flush_cnt) : 32'd0);
        // Advance model for the coming edge.
        m_stalled = rst && rdy && lu && !m_stalled;
        if (rst && e_bub && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (rst && e_fl && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    endtask

    task automatic idle();
        step(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
    endtask

    initial begin
        // Reset state.
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        step(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1);
        idle();

        // Load-use through rs2: one stall cycle, then back in RUN.
        step(1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1);
        check("lu_pc_stall",   32'(PC_write_o), 32'd0);
        check("lu_bubble",     32'(IDEX_bubble_o), 32'd1);
        step(1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1);
        check("lu_pc_release", 32'(PC_write_o), 32'd1);
        step(1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1);
        check("lu_run_again",  32'(IDEX_bubble_o), 32'd1);
        idle();

        // x0 never creates a hazard.
        step(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 1'b1);
        check("x0_no_stall", 32'(PC_write_o), 32'd1);

        // Load-use wins over a taken branch; branch flushes the next cycle.
        step(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1);
        check("lu_br_noflush", 32'(IFID_flush_o), 32'd0);
        step(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1);
        check("br_reflush",    32'(IFID_flush_o), 32'd1);
        idle();

        // Memory busy for 3 cycles during a load-use: freeze, then stall.
        repeat (3) begin
            step(1'b1, 5'd9, 5'd4, 1'b0, 1'b1, 5'd9, 1'b0);
            check("frz_active", 32'(freeze_o), 32'd1);
            check("frz_nobub",  32'(IDEX_bubble_o), 32'd0);
        end
        step(1'b1, 5'd9, 5'd4, 1'b0, 1'b1, 5'd9, 1'b1);
        check("frz_then_lu", 32'(IDEX_bubble_o), 32'd1);

        // Reset while in LU_STALL: reset outputs at once, RUN after release.
        step(1'b0, 5'd9, 5'd4, 1'b0, 1'b1, 5'd9, 1'b1);
        check("rst_mid_pc",  32'(PC_write_o), 32'd0);
        check("rst_mid_bub", 32'(IDEX_bubble_o), 32'd1);
        step(1'b1, 5'd9, 5'd4, 1'b0, 1'b1, 5'd9, 1'b1);
        check("rst_then_run", 32'(IDEX_bubble_o), 32'd1);
        idle();

        // Flush counter saturation.
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        repeat (20) step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1);
        idle();
        check("flush_sat", 32'(flush_cnt_o), PERF ? 32'd15 : 32'd0);
        idle();
        check("flush_hold", 32'(flush_cnt_o), PERF ? 32'd15 : 32'd0);

        // Randomized traffic over a small register window to hit hazards often.
        repeat (600) begin
            step(($urandom_range(0, 49) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one parameter: CNT_W, 32, width of the performance counters.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port ID_RS1addr_i, input, 5, rs1 of the instruction in ID.
REQ-005 The block SHALL have port ID_RS2addr_i, input, 5, rs2 of the instruction in ID.
REQ-006 The block SHALL have port ID_Branch_taken_i, input, 1, branch resolved taken in ID.
REQ-007 The block SHALL have port EX_MemRead_i, input, 1, MemRead bit of the ID_EX Control output.
REQ-008 The block SHALL have port EX_RDaddr_i, input, 5, RDaddr output of the ID_EX stage.
REQ-009 The block SHALL have port dmem_ready_i, input, 1, data memory ready; 0 = access in progress.
REQ-010 The block SHALL have port PC_write_o, output, 1, PC update enable.
REQ-011 The block SHALL have port IFID_write_o, output, 1, IF_ID load enable.
REQ-012 The block SHALL have port IFID_flush_o, output, 1, IF_ID instruction replaced by NOP.
REQ-013 The block SHALL have port IDEX_bubble_o, output, 1, zero the 8-bit Control into ID_EX.
REQ-014 The block SHALL have port freeze_o, output, 1, hold all pipeline registers.
REQ-015 The block SHALL have port stall_cnt_o, output, CNT_W, load-use stall cycle count.
REQ-016 The block SHALL have port flush_cnt_o, output, CNT_W, branch flush count.

Function
REQ-017 The block SHALL hold a registered FSM with states RUN, LU_STALL and FREEZE, encoded in 2 bits.
REQ-018 The block SHALL compute the load-use hazard LU as: EX_MemRead_i=1, EX_RDaddr_i!=0, and EX_RDaddr_i equal to ID_RS1addr_i or ID_RS2addr_i.
REQ-019 The block SHALL never detect a hazard through x0 (EX_RDaddr_i=0).
REQ-020 The block SHALL drive outputs combinationally from state and inputs, in the same cycle the condition appears.
REQ-021 The block SHALL apply priority FREEZE > LU > branch flush.
REQ-022 The block SHALL, when dmem_ready_i=0 in any state: set freeze_o=1, PC_write_o=0, IFID_write_o=0, IFID_flush_o=0, IDEX_bubble_o=0, and next state FREEZE.
REQ-023 The block SHALL, in FREEZE with dmem_ready_i=1, return to RUN and evaluate LU and branch normally that cycle.
REQ-024 The block SHALL, in RUN with LU=1: set PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, IFID_flush_o=0, and next state LU_STALL.
REQ-025 The block SHALL suppress ID_Branch_taken_i during an LU cycle; the branch re-resolves next cycle.
REQ-026 The block SHALL, in LU_STALL, never assert a second stall regardless of inputs, and drive PC_write_o=1 and IFID_write_o=1; next state RUN.
REQ-027 The block SHALL, in RUN or LU_STALL with no freeze and no LU, drive IFID_flush_o=ID_Branch_taken_i.
REQ-028 The block SHALL otherwise drive PC_write_o=1, IFID_write_o=1, IDEX_bubble_o=0, freeze_o=0.
REQ-029 The block SHALL make any LU stall last exactly 1 cycle.

Reset
REQ-030 The block SHALL, while rst_i=0: state=RUN, PC_write_o=0, IFID_write_o=0, IFID_flush_o=0, IDEX_bubble_o=1, freeze_o=0, counters=0.
REQ-031 The block SHALL, on reset mid-stall or mid-freeze, abandon that state immediately and start in RUN on the first edge after release.

Configuration
REQ-032 The block SHALL implement performance counters when HAZARD_PERF_CNT_EN is defined: stall_cnt_o +1 per cycle with IDEX_bubble_o=1 from LU; flush_cnt_o +1 per cycle with IFID_flush_o=1.
REQ-033 The block SHALL saturate each counter at all-ones, with no wrap.
REQ-034 The block SHALL, without HAZARD_PERF_CNT_EN, tie stall_cnt_o and flush_cnt_o to 0 and infer no counter flops.

Verification
REQ-035 The bench SHALL cover: EX_MemRead_i=1, EX_RDaddr_i=5, ID_RS2addr_i=5 -> that cycle PC_write_o=0, IDEX_bubble_o=1; next cycle PC_write_o=1, state RUN after.
REQ-036 The bench SHALL cover: EX_MemRead_i=1, EX_RDaddr_i=0, ID_RS1addr_i=0 -> no stall, PC_write_o=1.
REQ-037 The bench SHALL cover: LU and ID_Branch_taken_i=1 in the same cycle -> IFID_flush_o=0, stall taken; branch re-asserted next cycle -> IFID_flush_o=1.
REQ-038 The bench SHALL cover: dmem_ready_i=0 for 3 cycles during LU -> freeze_o=1 for 3 cycles, IDEX_bubble_o=0; LU is evaluated on the ready cycle.
REQ-039 The bench SHALL cover: rst_i to 0 while in LU_STALL -> outputs at reset values immediately; after release, the first cycle runs in RUN.
REQ-040 The bench SHALL cover, with HAZARD_PERF_CNT_EN and CNT_W=4: 20 flushes -> flush_cnt_o=15, held; without the macro -> 0.
